fpu_16bit_unit: RTL and testbench
=================================

# fpu_16bit_unit

Sequential IEEE-754 half-precision (binary16) arithmetic unit that computes X+Y, X−Y, X×Y or X÷Y under a 2-bit opcode. It also produces a three-way magnitude/sign comparison of X and Y. Each operation is started by releasing reset and ends with a sticky `done`. The block is a standalone datapath peripheral: the controller presents operands, pulses reset, waits for `done`, then reads `result`, `OFUF` and `compResult`.

## Interface
- No parameters.
- Clocking: one clock; reset is synchronous and active-low.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-low; low holds the unit idle; the first rising edge with `reset` high starts an operation.
- `X`  in  16  operand A, binary16 {sign, exp[4:0], frac[9:0]}, bias 15.
- `Y`  in  16  operand B, same format.
- `opcode`  in  2  0 = add, 1 = sub (X−Y), 2 = mul, 3 = div (X÷Y).
- `OFUF`  out  2  {overflow, underflow} flags, valid with `done`.
- `done`  out  1  high when result is valid; stays high until reset.
- `result`  out  16  binary16 result.
- `compResult`  out  3  {X>Y, X==Y, X<Y}, one-hot, valid with `done`.

## Operation
- States: IDLE, LOAD, EXEC, NORM, DONE.
  - IDLE is forced while `reset` is low.
  - LOAD: on the first edge with reset high, X, Y and opcode are registered; later input changes are ignored until the next reset.
- Operand decode:
  - exp = 0 means zero (subnormals are flushed to zero).
  - exp = 31 means infinity (fraction ignored).
  - Otherwise the significand is 1.frac.
- Add/sub:
  - Sub inverts Y's sign, then adds.
  - Swap so the larger magnitude is first; right-shift the smaller significand by the exponent difference into a 25-bit window (11 significand + 14 extension bits). Bits beyond the window are discarded.
  - Add or subtract the magnitudes, then normalize with a leading-one shift.
  - Exact zero gives +0 with no flags.
  - A zero operand returns the other operand (sign-adjusted for sub).
- Mul: sign = XOR of signs; exp = eX + eY − 15; 11×11 significand product (single cycle); normalize by 0 or 1 bit.
- Div: sign = XOR of signs; exp = eX − eY + 15. Significand quotient is computed by restoring division, one bit per cycle, 12 quotient bits; then normalize by 0 or 1 bit.
- Rounding: all results are truncated toward zero; extra bits are dropped after normalization.
- Overflow: final biased exp > 30, any infinity operand, or a nonzero dividend ÷ 0.
  - `result` = sign|11111|0000000000, `OFUF` = 2'b10.
- Underflow: final biased exp < 1 with a nonzero exact result.
  - `result` = sign|00000|0000000000, `OFUF` = 2'b01.
- Div: 0 ÷ nonzero → +0, no flags. 0 ÷ 0 → treated as overflow.
- compResult:
  - Computed from the latched operands by sign/exponent/fraction compare, independent of opcode.
  - +0 and −0 compare equal.
  - Exactly one bit is set.

## Timing
- Reset (reset low at an edge): `done` = 0, `result` = 16'h0000, `OFUF` = 2'b00, `compResult` = 3'b000, state = IDLE.
- Count edge 1 as the first edge with reset high (LOAD).
- Add/sub/mul: EXEC at edge 2, NORM at edge 3, `done` high after edge 4.
- Div: 12 EXEC iterations (edges 2–13), NORM at edge 14, `done` high after edge 15.
- Div early exit: if the exponent pre-check at edge 2 already forces under/overflow, or a special case applies, go straight to NORM; `done` high after edge 4.
- Outputs are registered. `result`, `OFUF` and `compResult` change only on entering DONE and hold until reset.
- Reset low mid-operation aborts on that edge and returns all outputs to reset values; a new operation starts on the next release.

## Test plan
- add 0x0F00 + 0x0B80 → 0x1160, OFUF 00, compResult 100, `done` 4 edges after release.
- add 0xD98D + 0x4F08 → 0xD8AC. Sub with the same operands → 0xDA6E. Sub 0x118D − 0xEF08 → 0x6F08. Sub 0x418D − 0xB308 → 0x41FD (truncation).
- mul 0x4F00 × 0x0B80 → 0x1E90; mul 0xD98D × 0x4F08 → 0xECE0; check 4-edge latency.
- div 0xD98D ÷ 0x4F08 → 0xC650 after 15 edges. Div 0x418D ÷ 0xB308 → 0xCA50. Div 0x118D ÷ 0xEF08 → underflow: OFUF 01, result 0x8000, `done` after 4 edges.
- Overflow: mul 0x7800 × 0x7800 → 0x7C00 with OFUF 10; div 0x3C00 ÷ 0x0000 → 0x7C00 with OFUF 10.
- Compare/reset: X = Y = 0x3C00 → compResult 010. Pull reset low mid-divide → outputs cleared next edge, `done` stays 0.

Source files
------------

// File: rtl/fpu_16bit_unit_if.sv
// Operand/result bundle for the half-precision arithmetic unit.
// The controller drives operands and opcode; the unit returns result and flags.
interface fpu_16bit_unit_if;
    logic [15:0] X;
    logic [15:0] Y;
    logic [1:0]  opcode;
    logic [1:0]  OFUF;
    logic        done;
    logic [15:0] result;
    logic [2:0]  compResult;

    modport master (output X, Y, opcode, input OFUF, done, result, compResult);
    modport slave  (input X, Y, opcode, output OFUF, done, result, compResult);
endinterface

// File: rtl/fpu_16bit_unit.sv
// Sequential binary16 add/sub/mul/div unit with truncating rounding,
// overflow/underflow flags and a three-way operand compare.
module fpu_16bit_unit (
    input  logic            clk,
    input  logic            reset,
    fpu_16bit_unit_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        EXEC = 3'd2,
        NORM = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    // Magnitude key: zeros collapse to 0, infinities ignore their fraction.
    function automatic logic [14:0] mag_key(input logic [15:0] v);
        logic [14:0] k;
        if (v[14:10] == 5'd0) begin
            k = 15'd0;
        end else if (v[14:10] == 5'h1F) begin
            k = {5'h1F, 10'd0};
        end else begin
            k = v[14:0];
        end
        return k;
    endfunction

    function automatic logic [10:0] sig_of(input logic [15:0] v);
        return (v[14:10] == 5'd0) ? 11'd0 : {1'b1, v[9:0]};
    endfunction

    function automatic logic [2:0] cmp3(input logic [15:0] a, input logic [15:0] b);
        logic [14:0] ka;
        logic [14:0] kb;
        logic        sa;
        logic        sb;
        logic [2:0]  r;
        ka = mag_key(a);
        kb = mag_key(b);
        sa = a[15] & (ka != 15'd0);
        sb = b[15] & (kb != 15'd0);
        if ((ka == kb) && (sa == sb)) begin
            r = 3'b010;
        end else if (sa != sb) begin
            r = sa ? 3'b001 : 3'b100;
        end else if (!sa) begin
            r = (ka > kb) ? 3'b100 : 3'b001;
        end else begin
            r = (ka > kb) ? 3'b001 : 3'b100;
        end
        return r;
    endfunction

    function automatic logic [4:0] lead_one(input logic [25:0] v);
        logic [4:0] pos;
        pos = 5'd0;
        for (int i = 0; i < 26; i++) begin
            pos = v[i] ? 5'(i) : pos;
        end
        return pos;
    endfunction

    state_t            state_r;
    logic [15:0]       x_r;
    logic [15:0]       y_r;
    logic [1:0]        op_r;
    logic              sign_r;
    logic signed [7:0] exp_r;
    logic              spec_zero_r;
    logic              spec_ovf_r;
    logic              spec_unf_r;
    logic [24:0]       a_r;
    logic [24:0]       b_r;
    logic              sub_r;
    logic [25:0]       acc_r;
    logic [3:0]        cnt_r;
    logic [15:0]       result_r;
    logic [1:0]        ofuf_r;
    logic              done_r;
    logic [2:0]        cmp_r;

    logic              xs_s, ys_s, xz_s, yz_s, xi_s, yi_s, x_big_s;
    logic [10:0]       xm_s, ym_s;
    logic [4:0]        diff_s;
    logic signed [7:0] mul_exp_s, div_exp_s;
    logic [2:0]        cmp_s;
    logic              ld_sign_s, ld_sub_s, ld_zero_s, ld_ovf_s, ld_unf_s;
    logic signed [7:0] ld_exp_s;
    logic [24:0]       ld_a_s, ld_b_s;
    logic              q_bit_s;
    logic [10:0]       rem_s;
    logic [21:0]       prod_s;
    logic [25:0]       sum_s;
    logic [4:0]        lead_s;
    logic [9:0]        frac_s;
    logic signed [7:0] exp_fin_s;
    logic [15:0]       res_s;
    logic [1:0]        flags_s;

    assign bus.result     = result_r;
    assign bus.OFUF       = ofuf_r;
    assign bus.done       = done_r;
    assign bus.compResult = cmp_r;

    // Operand decode and alignment prepared from the latched operands.
    always_comb begin
        xs_s      = x_r[15];
        ys_s      = y_r[15] ^ (op_r == OP_SUB);
        xz_s      = (x_r[14:10] == 5'd0);
        yz_s      = (y_r[14:10] == 5'd0);
        xi_s      = (x_r[14:10] == 5'h1F);
        yi_s      = (y_r[14:10] == 5'h1F);
        xm_s      = sig_of(x_r);
        ym_s      = sig_of(y_r);
        x_big_s   = (mag_key(x_r) >= mag_key(y_r));
        diff_s    = x_big_s ? (x_r[14:10] - y_r[14:10]) : (y_r[14:10] - x_r[14:10]);
        mul_exp_s = $signed({3'b000, x_r[14:10]}) + $signed({3'b000, y_r[14:10]}) - 8'sd15;
        div_exp_s = $signed({3'b000, x_r[14:10]}) - $signed({3'b000, y_r[14:10]}) + 8'sd15;
        cmp_s     = cmp3(x_r, y_r);

        ld_sub_s  = 1'b0;
        ld_zero_s = 1'b0;
        ld_unf_s  = 1'b0;
        ld_ovf_s  = xi_s | yi_s;
        ld_sign_s = xs_s ^ y_r[15];
        ld_a_s    = {14'd0, xm_s};
        ld_b_s    = {14'd0, ym_s};
        case (op_r)
            OP_MUL: begin
                ld_exp_s  = mul_exp_s;
                ld_zero_s = !ld_ovf_s && (xz_s || yz_s);
            end
            OP_DIV: begin
                // Exponent pre-check lets hopeless quotients skip the iterations.
                ld_exp_s  = div_exp_s;
                ld_ovf_s  = xi_s | yi_s | yz_s | (!xz_s && (div_exp_s > 8'sd31));
                ld_zero_s = !ld_ovf_s && xz_s;
                ld_unf_s  = !ld_ovf_s && !xz_s && (div_exp_s < 8'sd1);
            end
            default: begin
                ld_sign_s = x_big_s ? xs_s : ys_s;
                ld_sub_s  = xs_s ^ ys_s;
                ld_exp_s  = $signed({3'b000, x_big_s ? x_r[14:10] : y_r[14:10]});
                ld_a_s    = {(x_big_s ? xm_s : ym_s), 14'd0};
                ld_b_s    = {(x_big_s ? ym_s : xm_s), 14'd0} >> diff_s;
            end
        endcase
    end

    // Per-cycle arithmetic: one restoring-division step, product and aligned sum.
    always_comb begin
        q_bit_s = (a_r[11:0] >= {1'b0, b_r[10:0]});
        rem_s   = q_bit_s ? 11'(a_r[11:0] - {1'b0, b_r[10:0]}) : a_r[10:0];
        prod_s  = 22'(a_r[10:0]) * 22'(b_r[10:0]);
        sum_s   = sub_r ? ({1'b0, a_r} - {1'b0, b_r}) : ({1'b0, a_r} + {1'b0, b_r});
    end

    // Normalization, truncation and exception encoding of the final result.
    always_comb begin
        lead_s = lead_one(acc_r);
        case (op_r)
            OP_MUL: begin
                frac_s    = acc_r[21] ? acc_r[20:11] : acc_r[19:10];
                exp_fin_s = acc_r[21] ? (exp_r + 8'sd1) : exp_r;
            end
            OP_DIV: begin
                frac_s    = acc_r[11] ? acc_r[10:1] : acc_r[9:0];
                exp_fin_s = acc_r[11] ? exp_r : (exp_r - 8'sd1);
            end
            default: begin
                frac_s    = 10'((acc_r << (5'd25 - lead_s)) >> 15);
                exp_fin_s = exp_r + $signed({3'b000, lead_s}) - 8'sd24;
            end
        endcase

        if (spec_ovf_r) begin
            res_s = {sign_r, 5'h1F, 10'd0};  flags_s = 2'b10;
        end else if (spec_zero_r) begin
            res_s = 16'h0000;                flags_s = 2'b00;
        end else if (spec_unf_r) begin
            res_s = {sign_r, 15'd0};         flags_s = 2'b01;
        end else if (acc_r == 26'd0) begin
            res_s = 16'h0000;                flags_s = 2'b00;
        end else if (exp_fin_s > 8'sd30) begin
            res_s = {sign_r, 5'h1F, 10'd0};  flags_s = 2'b10;
        end else if (exp_fin_s < 8'sd1) begin
            res_s = {sign_r, 15'd0};         flags_s = 2'b01;
        end else begin
            res_s = {sign_r, exp_fin_s[4:0], frac_s};  flags_s = 2'b00;
        end
    end

    // Control FSM with all datapath and output registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= IDLE;
            x_r         <= 16'h0000;
            y_r         <= 16'h0000;
            op_r        <= 2'd0;
            sign_r      <= 1'b0;
            exp_r       <= 8'sd0;
            spec_zero_r <= 1'b0;
            spec_ovf_r  <= 1'b0;
            spec_unf_r  <= 1'b0;
            a_r         <= 25'd0;
            b_r         <= 25'd0;
            sub_r       <= 1'b0;
            acc_r       <= 26'd0;
            cnt_r       <= 4'd0;
            result_r    <= 16'h0000;
            ofuf_r      <= 2'b00;
            done_r      <= 1'b0;
            cmp_r       <= 3'b000;
        end else begin
            case (state_r)
                IDLE: begin
                    x_r     <= bus.X;
                    y_r     <= bus.Y;
                    op_r    <= bus.opcode;
                    state_r <= LOAD;
                end
                LOAD: begin
                    sign_r      <= ld_sign_s;
                    exp_r       <= ld_exp_s;
                    spec_zero_r <= ld_zero_s;
                    spec_ovf_r  <= ld_ovf_s;
                    spec_unf_r  <= ld_unf_s;
                    a_r         <= ld_a_s;
                    b_r         <= ld_b_s;
                    sub_r       <= ld_sub_s;
                    acc_r       <= 26'd0;
                    cnt_r       <= 4'd0;
                    state_r     <= EXEC;
                end
                EXEC: begin
                    case (op_r)
                        OP_MUL: begin
                            acc_r   <= {4'd0, prod_s};
                            state_r <= NORM;
                        end
                        OP_DIV: begin
                            if (spec_zero_r || spec_ovf_r || spec_unf_r) begin
                                state_r <= NORM;
                            end else begin
                                acc_r   <= {acc_r[24:0], q_bit_s};
                                a_r     <= {13'd0, rem_s, 1'b0};
                                cnt_r   <= cnt_r + 4'd1;
                                state_r <= (cnt_r == 4'd11) ? NORM : EXEC;
                            end
                        end
                        default: begin
                            acc_r   <= sum_s;
                            state_r <= NORM;
                        end
                    endcase
                end
                NORM: begin
                    result_r <= res_s;
                    ofuf_r   <= flags_s;
                    cmp_r    <= cmp_s;
                    done_r   <= 1'b1;
                    state_r  <= DONE;
                end
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_16bit_unit.sv
// Directed bench for fpu_16bit_unit: hand-computed binary16 vectors,
// latency checks, exception encodings and mid-operation reset abort.
module tb_fpu_16bit_unit;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    fpu_16bit_unit_if ifc ();

    fpu_16bit_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  op;
        logic [15:0] res;
        logic [1:0]  fl;
        logic [2:0]  cmp;
        logic [4:0]  lat;
    } vec_t;

    function automatic vec_t mk(input logic [15:0] x, input logic [15:0] y, input logic [1:0] op,
                                input logic [15:0] res, input logic [1:0] fl, input logic [2:0] cmp,
                                input logic [4:0] lat);
        vec_t v;
        v.x = x; v.y = y; v.op = op; v.res = res; v.fl = fl; v.cmp = cmp; v.lat = lat;
        return v;
    endfunction

    // Reset pulse, release, scramble inputs after capture, count edges until done.
    task automatic run_op(input logic [15:0] x, input logic [15:0] y, input logic [1:0] op,
                          output int edges);
        logic seen;
        @(negedge clk);
        reset = 1'b0;
        ifc.X = x; ifc.Y = y; ifc.opcode = op;
        @(negedge clk);
        reset = 1'b1;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (edges == 1) begin
                ifc.X = ~x; ifc.Y = ~y; ifc.opcode = ~op;
            end
            seen = ifc.done;
        end
    endtask

    task automatic test_reset();
        int edges;
        reset = 1'b0;
        ifc.X = 16'h0000; ifc.Y = 16'h0000; ifc.opcode = 2'd0;
        repeat (2) @(negedge clk);
        total++; if (ifc.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", ifc.done); end
        total++; if (ifc.result !== 16'h0000) begin bad++; $display("FAIL reset_result got=%h want=0000", ifc.result); end
        total++; if (ifc.OFUF !== 2'b00) begin bad++; $display("FAIL reset_ofuf got=%b want=00", ifc.OFUF); end
        total++; if (ifc.compResult !== 3'b000) begin bad++; $display("FAIL reset_cmp got=%b want=000", ifc.compResult); end
        run_op(16'h0F00, 16'h0B80, 2'd0, edges);
        reset = 1'b0;
        @(negedge clk);
        total++; if (ifc.done !== 1'b0) begin bad++; $display("FAIL reclear_done got=%b want=0", ifc.done); end
        total++; if (ifc.result !== 16'h0000) begin bad++; $display("FAIL reclear_result got=%h want=0000", ifc.result); end
        total++; if (ifc.compResult !== 3'b000) begin bad++; $display("FAIL reclear_cmp got=%b want=000", ifc.compResult); end
    endtask

    task automatic test_add_sub();
        vec_t v[7];
        int   edges;
        v[0] = mk(16'h0F00, 16'h0B80, 2'd0, 16'h1160, 2'b00, 3'b100, 5'd4);
        v[1] = mk(16'hD98D, 16'h4F08, 2'd0, 16'hD8AC, 2'b00, 3'b001, 5'd4);
        v[2] = mk(16'hD98D, 16'h4F08, 2'd1, 16'hDA6E, 2'b00, 3'b001, 5'd4);
        v[3] = mk(16'h118D, 16'hEF08, 2'd1, 16'h6F08, 2'b00, 3'b100, 5'd4);
        v[4] = mk(16'h418D, 16'hB308, 2'd1, 16'h41FD, 2'b00, 3'b100, 5'd4);
        v[5] = mk(16'h3C00, 16'h3C00, 2'd1, 16'h0000, 2'b00, 3'b010, 5'd4);
        v[6] = mk(16'h0000, 16'h4F08, 2'd1, 16'hCF08, 2'b00, 3'b001, 5'd4);
        foreach (v[i]) begin
            run_op(v[i].x, v[i].y, v[i].op, edges);
            total++; if (ifc.result !== v[i].res) begin bad++; $display("FAIL addsub[%0d] result got=%h want=%h", i, ifc.result, v[i].res); end
            total++; if (ifc.OFUF !== v[i].fl) begin bad++; $display("FAIL addsub[%0d] ofuf got=%b want=%b", i, ifc.OFUF, v[i].fl); end
            total++; if (ifc.compResult !== v[i].cmp) begin bad++; $display("FAIL addsub[%0d] cmp got=%b want=%b", i, ifc.compResult, v[i].cmp); end
            total++; if (edges !== int'(v[i].lat)) begin bad++; $display("FAIL addsub[%0d] latency got=%0d want=%0d", i, edges, v[i].lat); end
        end
    endtask

    task automatic test_mul();
        vec_t v[2];
        int   edges;
        v[0] = mk(16'h4F00, 16'h0B80, 2'd2, 16'h1E90, 2'b00, 3'b100, 5'd4);
        v[1] = mk(16'hD98D, 16'h4F08, 2'd2, 16'hECE0, 2'b00, 3'b001, 5'd4);
        foreach (v[i]) begin
            run_op(v[i].x, v[i].y, v[i].op, edges);
            total++; if (ifc.result !== v[i].res) begin bad++; $display("FAIL mul[%0d] result got=%h want=%h", i, ifc.result, v[i].res); end
            total++; if (ifc.OFUF !== v[i].fl) begin bad++; $display("FAIL mul[%0d] ofuf got=%b want=%b", i, ifc.OFUF, v[i].fl); end
            total++; if (ifc.compResult !== v[i].cmp) begin bad++; $display("FAIL mul[%0d] cmp got=%b want=%b", i, ifc.compResult, v[i].cmp); end
            total++; if (edges !== int'(v[i].lat)) begin bad++; $display("FAIL mul[%0d] latency got=%0d want=%0d", i, edges, v[i].lat); end
        end
    endtask

    task automatic test_div();
        vec_t v[3];
        int   edges;
        v[0] = mk(16'hD98D, 16'h4F08, 2'd3, 16'hC650, 2'b00, 3'b001, 5'd15);
        v[1] = mk(16'h418D, 16'hB308, 2'd3, 16'hCA50, 2'b00, 3'b100, 5'd15);
        v[2] = mk(16'h118D, 16'hEF08, 2'd3, 16'h8000, 2'b01, 3'b100, 5'd4);
        foreach (v[i]) begin
            run_op(v[i].x, v[i].y, v[i].op, edges);
            total++; if (ifc.result !== v[i].res) begin bad++; $display("FAIL div[%0d] result got=%h want=%h", i, ifc.result, v[i].res); end
            total++; if (ifc.OFUF !== v[i].fl) begin bad++; $display("FAIL div[%0d] ofuf got=%b want=%b", i, ifc.OFUF, v[i].fl); end
            total++; if (ifc.compResult !== v[i].cmp) begin bad++; $display("FAIL div[%0d] cmp got=%b want=%b", i, ifc.compResult, v[i].cmp); end
            total++; if (edges !== int'(v[i].lat)) begin bad++; $display("FAIL div[%0d] latency got=%0d want=%0d", i, edges, v[i].lat); end
        end
    endtask

    task automatic test_overflow();
        vec_t v[3];
        int   edges;
        v[0] = mk(16'h7800, 16'h7800, 2'd2, 16'h7C00, 2'b10, 3'b010, 5'd4);
        v[1] = mk(16'h3C00, 16'h0000, 2'd3, 16'h7C00, 2'b10, 3'b100, 5'd4);
        v[2] = mk(16'h7C00, 16'h3C00, 2'd0, 16'h7C00, 2'b10, 3'b100, 5'd4);
        foreach (v[i]) begin
            run_op(v[i].x, v[i].y, v[i].op, edges);
            total++; if (ifc.result !== v[i].res) begin bad++; $display("FAIL ovf[%0d] result got=%h want=%h", i, ifc.result, v[i].res); end
            total++; if (ifc.OFUF !== v[i].fl) begin bad++; $display("FAIL ovf[%0d] ofuf got=%b want=%b", i, ifc.OFUF, v[i].fl); end
            total++; if (ifc.compResult !== v[i].cmp) begin bad++; $display("FAIL ovf[%0d] cmp got=%b want=%b", i, ifc.compResult, v[i].cmp); end
            total++; if (edges !== int'(v[i].lat)) begin bad++; $display("FAIL ovf[%0d] latency got=%0d want=%0d", i, edges, v[i].lat); end
        end
    endtask

    task automatic test_compare();
        vec_t v[2];
        int   edges;
        v[0] = mk(16'h3C00, 16'h3C00, 2'd0, 16'h4000, 2'b00, 3'b010, 5'd4);
        v[1] = mk(16'h8000, 16'h0000, 2'd0, 16'h0000, 2'b00, 3'b010, 5'd4);
        foreach (v[i]) begin
            run_op(v[i].x, v[i].y, v[i].op, edges);
            total++; if (ifc.result !== v[i].res) begin bad++; $display("FAIL cmp[%0d] result got=%h want=%h", i, ifc.result, v[i].res); end
            total++; if (ifc.compResult !== v[i].cmp) begin bad++; $display("FAIL cmp[%0d] cmp got=%b want=%b", i, ifc.compResult, v[i].cmp); end
            total++; if (edges !== int'(v[i].lat)) begin bad++; $display("FAIL cmp[%0d] latency got=%0d want=%0d", i, edges, v[i].lat); end
        end
    endtask

    task automatic test_abort();
        int edges;
        @(negedge clk);
        reset = 1'b0;
        ifc.X = 16'hD98D; ifc.Y = 16'h4F08; ifc.opcode = 2'd3;
        @(negedge clk);
        reset = 1'b1;
        repeat (6) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        total++; if (ifc.done !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", ifc.done); end
        total++; if (ifc.result !== 16'h0000) begin bad++; $display("FAIL abort_result got=%h want=0000", ifc.result); end
        total++; if (ifc.OFUF !== 2'b00) begin bad++; $display("FAIL abort_ofuf got=%b want=00", ifc.OFUF); end
        repeat (12) @(negedge clk);
        total++; if (ifc.done !== 1'b0) begin bad++; $display("FAIL abort_hold_done got=%b want=0", ifc.done); end
        run_op(16'h418D, 16'hB308, 2'd3, edges);
        total++; if (ifc.result !== 16'hCA50) begin bad++; $display("FAIL abort_rerun result got=%h want=CA50", ifc.result); end
        total++; if (edges !== 15) begin bad++; $display("FAIL abort_rerun latency got=%0d want=15", edges); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_add_sub();
        test_mul();
        test_div();
        test_overflow();
        test_compare();
        test_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
